// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit back end.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with occupancy count. Pointers wrap modulo DEPTH (power of two).
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [7:0]             data_i,
  input  logic                   pop_i,
  output logic [7:0]             data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  // A push while full is refused even if a pop happens on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for 8E1
// (even parity bit inserted between the data bits and the stop bit).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] wr_data_i,
  input  logic       wr_en_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       overflow_o
);
  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] RELOAD   = CW'(DIV - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic          pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_data;
  logic [AW:0]   fifo_count;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wr_en_i),
    .data_i  (wr_data_i),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign ready_o    = !fifo_full;
  assign busy_o     = (state_q != IDLE) || (fifo_count != '0);
  assign overflow_o = ovf_q;
  assign tx_o       = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    // One shared bit timer: every non-idle state lasts DIV cycles.
    if (state_q != IDLE) baud_d = (baud_q == '0) ? RELOAD : baud_q - 1'b1;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        shift_d = fifo_data;
        baud_d  = RELOAD;
        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
        par_d   = ^fifo_data;
`endif
        state_d = START;
      end
      START: if (baud_q == '0) state_d = DATA;
      DATA: if (baud_q == '0) begin
        shift_d = shift_q >> 1;
        if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_q == '0) state_d = STOP;
`endif
      STOP: if (baud_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line level is a registered decode of the current state, so it trails state by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      if (wr_en_i && fifo_full) ovf_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: line decoder plus queue-based reference model.
module tb_uart_tx_fifo;
  localparam int DIV   = 16;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ready, tx, busy, ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_data_i  (wr_data),
    .wr_en_i    (wr_en),
    .ready_o    (ready),
    .tx_o       (tx),
    .busy_o     (busy),
    .overflow_o (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Line decoder: samples mid-bit and records byte, start edge, parity and stop level.
  logic [7:0] got_q[$];
  int         st_q[$];
  bit         pb_q[$];
  bit         sp_q[$];

  initial begin
    int s;
    logic [7:0] b;
    bit p, sp;
    forever begin
      @(posedge clk); #2;
      if (tx === 1'b0) begin
        s = cyc;
        repeat (DIV/2) @(posedge clk);
        #2;
        if (tx === 1'b0) begin
          for (int k = 0; k < 8; k++) begin
            repeat (DIV) @(posedge clk);
            #2;
            b[k] = tx;
          end
          p = 1'b0;
`ifdef UART_TX_PARITY_EN
          repeat (DIV) @(posedge clk);
          #2;
          p = tx;
`endif
          repeat (DIV) @(posedge clk);
          #2;
          sp = tx;
          got_q.push_back(b);
          st_q.push_back(s);
          pb_q.push_back(p);
          sp_q.push_back(sp);
        end
      end
    end
  end

  // Reference model state: expected byte order and FIFO occupancy.
  logic [7:0] exp_q[$];
  int         occ;
  bit         ovf_exp;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  function automatic void model_push(input logic [7:0] b);
    if (occ < DEPTH) begin
      occ++;
      exp_q.push_back(b);
    end else begin
      ovf_exp = 1'b1;
    end
  endfunction

  task automatic clear_all();
    got_q.delete(); st_q.delete(); pb_q.delete(); sp_q.delete(); exp_q.delete();
    occ = 0;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (got_q.size() < n && t < n * FRAME + 400) begin
      tick();
      t++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    ovf_exp = 1'b0;
    clear_all();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_single();
    int n;
    clear_all();
    push(8'h55);
    n = cyc;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_push: got %b want 1", busy); end
    while (cyc < n + FRAME - 1) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_stop: got %b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    wait_frames(1);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL single_frames: got %0d want 1", got_q.size());
    end else begin
      if (got_q[0] !== 8'h55) begin errors++; $display("FAIL single_byte: got %h want 55", got_q[0]); end
      checks++; if (st_q[0] != n + 2) begin errors++; $display("FAIL single_latency: got %0d want %0d", st_q[0] - n, 2); end
      checks++; if (sp_q[0] !== 1'b1) begin errors++; $display("FAIL single_stop: got %b want 1", sp_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_all();
    push(8'hA3);
    n = cyc;
    push(8'h0F);
    wait_frames(2);
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL b2b_frames: got %0d want 2", got_q.size());
    end else begin
      if (got_q[0] !== 8'hA3 || got_q[1] !== 8'h0F) begin
        errors++; $display("FAIL b2b_bytes: got %h %h want a3 0f", got_q[0], got_q[1]);
      end
      checks++; if (st_q[0] != n + 2) begin errors++; $display("FAIL b2b_latency: got %0d want 2", st_q[0] - n); end
      checks++; if (st_q[1] - st_q[0] != FRAME) begin
        errors++; $display("FAIL b2b_period: got %0d want %0d", st_q[1] - st_q[0], FRAME);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    int bad;
    clear_all();
    b = 8'($urandom);
    push(b);
    exp_q.push_back(b);   // popped on the next edge, never counts toward occupancy
    tick();
    for (int k = 0; k < DEPTH + 1; k++) begin
      b = 8'($urandom);
      push(b);
      model_push(b);
      checks++; if (ready !== (occ != DEPTH)) begin
        errors++; $display("FAIL ovf_ready[%0d]: got %b want %b", k, ready, occ != DEPTH);
      end
      checks++; if (ovf !== ovf_exp) begin
        errors++; $display("FAIL ovf_flag[%0d]: got %b want %b", k, ovf, ovf_exp);
      end
    end
    wait_frames(exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || sp_q[i] !== 1'b1) bad++;
    checks++; if (bad != 0 || got_q.size() != 17) begin
      errors++; $display("FAIL ovf_sequence: got %0d frames %0d bad want 17 frames 0 bad", got_q.size(), bad);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] b;
    int n, bad;
    do_reset();
    b = 8'($urandom);
    push(b);
    n = cyc;
    exp_q.push_back(b);
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      b = 8'($urandom);
      push(b);
      model_push(b);
    end
    while (cyc < n + FRAME) tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fullpop_ready_pre: got %b want 0", ready); end
    checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL fullpop_ovf_pre: got %b want 0", ovf); end
    // This push lands on the pop edge: dropped, then one entry leaves.
    b = 8'($urandom);
    push(b);
    model_push(b);
    occ--;
    checks++; if (ovf !== ovf_exp) begin errors++; $display("FAIL fullpop_ovf: got %b want %b", ovf, ovf_exp); end
    checks++; if (ready !== (occ != DEPTH)) begin
      errors++; $display("FAIL fullpop_ready_post: got %b want %b", ready, occ != DEPTH);
    end
    b = 8'($urandom);
    push(b);
    model_push(b);
    checks++; if (ready !== (occ != DEPTH)) begin
      errors++; $display("FAIL fullpop_refill: got %b want %b", ready, occ != DEPTH);
    end
    wait_frames(exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0 || got_q.size() != 18) begin
      errors++; $display("FAIL fullpop_sequence: got %0d frames %0d bad want 18 frames 0 bad", got_q.size(), bad);
    end
  endtask

  task automatic test_reset_mid();
    int n, bad;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL midrst_ovf_pre: got %b want 1", ovf); end
    push(8'hFF);
    n = cyc;
    tick();
    for (int k = 0; k < 3; k++) push(8'($urandom));
    while (cyc < n + 59) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL midrst_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", ready); end
    checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
    bad = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles want 0", bad); end
    // Reset during a start bit must lift the line on the very next edge.
    push(8'h00);
    n = cyc;
    while (cyc < n + 7) tick();
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL startrst_pre: got %b want 0", tx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL startrst_tx: got %b want 1", tx); end
    repeat (FRAME + 20) tick();
    clear_all();
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    clear_all();
    push(8'h07);
    push(8'h03);
    wait_frames(2);
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL par_frames: got %0d want 2", got_q.size());
    end else begin
      if (got_q[0] !== 8'h07 || got_q[1] !== 8'h03) begin
        errors++; $display("FAIL par_bytes: got %h %h want 07 03", got_q[0], got_q[1]);
      end
      checks++; if (pb_q[0] !== ^8'h07 || pb_q[1] !== ^8'h03) begin
        errors++; $display("FAIL par_bits: got %b %b want 1 0", pb_q[0], pb_q[1]);
      end
      checks++; if (st_q[1] - st_q[0] != 177) begin
        errors++; $display("FAIL par_period: got %0d want 177", st_q[1] - st_q[0]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] b;
    int bad;
    clear_all();
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom);
      push(b);
      exp_q.push_back(b);
      repeat ($urandom_range(0, 300)) tick();
    end
    wait_frames(exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || sp_q[i] !== 1'b1
          || pb_q[i] !== ((NBITS == 11) ? ^exp_q[i] : 1'b0)) bad++;
    checks++; if (bad != 0 || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_sequence: got %0d frames %0d bad want %0d frames 0 bad",
                         got_q.size(), bad, exp_q.size());
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL random_ovf: got %b want 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
